// File: rtl/key_click_classifier_if.sv
// Click-classifier bus: debounced press pulse in, click event out over a
// one-entry valid/ready register, plus status flags.
interface key_click_classifier_if;
  logic       btn_pulse;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       evt_overflow;
  logic       busy;

  // Classifier side: consumes pulses, produces events.
  modport master (
    input  btn_pulse,
    input  evt_ready,
    output evt_valid,
    output evt_code,
    output evt_overflow,
    output busy
  );

  // Control-logic side: provides pulses and accepts events.
  modport slave (
    output btn_pulse,
    output evt_ready,
    input  evt_valid,
    input  evt_code,
    input  evt_overflow,
    input  busy
  );
endinterface

// File: rtl/key_click_classifier.sv
// Groups debounced button pulses arriving within a click window into single,
// double or triple events, presented through a one-entry valid/ready register.
module key_click_classifier #(
  parameter int WINDOW_CYCLES = 30_000_000,
  parameter int CNT_W         = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  key_click_classifier_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(WINDOW_CYCLES - 1);

  localparam logic [1:0] CODE_SINGLE = 2'b01;
  localparam logic [1:0] CODE_DOUBLE = 2'b10;
  localparam logic [1:0] CODE_TRIPLE = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             emit;
  logic [1:0]       emit_code;

  logic             evt_valid_q;
  logic [1:0]       evt_code_q;
  logic             evt_overflow_q;
  logic             slot_free;

  // Window FSM: state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A pulse always wins over the terminal count, so a click landing on the
  // last window cycle extends the sequence instead of emitting a timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_code = 2'b00;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.btn_pulse) state_d = ONE;
      end
      ONE: begin
        if (bus.btn_pulse) begin
          state_d = TWO;
          cnt_d   = '0;
        end else if (cnt_q == TERM_CNT) begin
          state_d   = IDLE;
          cnt_d     = '0;
          emit      = 1'b1;
          emit_code = CODE_SINGLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TWO: begin
        if (bus.btn_pulse) begin
          state_d   = IDLE;
          cnt_d     = '0;
          emit      = 1'b1;
          emit_code = CODE_TRIPLE;
        end else if (cnt_q == TERM_CNT) begin
          state_d   = IDLE;
          cnt_d     = '0;
          emit      = 1'b1;
          emit_code = CODE_DOUBLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign slot_free = !evt_valid_q || bus.evt_ready;

  // Output slot: a same-edge accept frees the slot for a new event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid_q    <= 1'b0;
      evt_code_q     <= 2'b00;
      evt_overflow_q <= 1'b0;
    end else begin
      if (emit && slot_free) begin
        evt_valid_q <= 1'b1;
        evt_code_q  <= emit_code;
      end else if (emit) begin
        evt_overflow_q <= 1'b1;
      end else if (evt_valid_q && bus.evt_ready) begin
        evt_valid_q <= 1'b0;
      end
    end
  end

  assign bus.evt_valid    = evt_valid_q;
  assign bus.evt_code     = evt_code_q;
  assign bus.evt_overflow = evt_overflow_q;
  assign bus.busy         = (state_q != IDLE);

endmodule
